// File: rtl/tree_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : tree_mem_pkg
//  Description : Shared types for the tree node memory arbiter: FSM state
//                encoding, read-return tag record and an address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tree_mem_pkg;

    // Widest stage index a tag can carry (up to 256 requesting stages)
    localparam int c_STAGE_IDX_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CFG   = 2'd2
    } state_t;

    typedef struct packed {
        logic                     valid;
        logic [c_STAGE_IDX_W-1:0] stage;
    } tag_t;

    // Address width for a given depth, never narrower than one bit
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tree_node_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Picks the first eligible
//                requester at or above i_ptr, wrapping around. The pointer
//                register itself is owned by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_STAGES = 4
) (
    input  logic [NUM_STAGES-1:0]         i_eligible,
    input  logic [$clog2(NUM_STAGES)-1:0] i_ptr,
    output logic                          o_valid,
    output logic [$clog2(NUM_STAGES)-1:0] o_idx
);

    localparam int SW = $clog2(NUM_STAGES);

    logic [2*NUM_STAGES-1:0] w_rot;
    int                      w_sum;

    // Rotate the eligible vector so bit 0 is the pointer stage, then take the first set bit
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = 0;
        w_rot   = {i_eligible, i_eligible} >> i_ptr;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (!o_valid && w_rot[k]) begin
                o_valid = 1'b1;
                w_sum   = int'(i_ptr) + k;
                if (w_sum >= NUM_STAGES) begin
                    w_sum = w_sum - NUM_STAGES;
                end
                o_idx = SW'(w_sum);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tree_node_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tree_node_mem_arbiter
//  Description : Shares one single-ported synchronous node RAM between the
//                pipeline stages. Round-robin read arbitration, tagged read
//                return with per-stage memRdy, and a configuration write port
//                that first drains every in-flight read.
//                Optional statistics counters: define TREE_MEM_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tree_node_mem_arbiter
    import tree_mem_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int NUM_NODES  = 32,
    parameter int WORD_W     = 64,
    parameter int RD_LAT     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_STAGES-1:0]                 req,
    input  logic [NUM_STAGES*$clog2(NUM_NODES)-1:0] reqAddr,
    output logic [NUM_STAGES-1:0]                 memRdy,
    output logic [WORD_W-1:0]                     rdData,
    input  logic                                  cfgValid,
    input  logic [$clog2(NUM_NODES)-1:0]          cfgAddr,
    input  logic [WORD_W-1:0]                     cfgData,
    output logic                                  cfgReady,
    output logic                                  ramEn,
    output logic                                  ramWe,
    output logic [$clog2(NUM_NODES)-1:0]          ramAddr,
    output logic [WORD_W-1:0]                     ramWdata,
    input  logic [WORD_W-1:0]                     ramRdata,
    output logic                                  busy
`ifdef TREE_MEM_STATS_EN
    ,
    output logic [31:0]                           grantCount,
    output logic [31:0]                           stallCount
`endif
);

    localparam int AW = addr_w(NUM_NODES);
    localparam int SW = addr_w(NUM_STAGES);
    localparam int CW = $clog2(RD_LAT + 1) + 1;

    state_t                r_state;
    logic [SW-1:0]         r_ptr;
    logic [NUM_STAGES-1:0] r_outstanding;
    logic [CW-1:0]         r_inflight;
    tag_t                  r_tags [RD_LAT];

    logic [NUM_STAGES-1:0] w_eligible;
    logic [NUM_STAGES-1:0] w_grant_mask;
    logic [NUM_STAGES-1:0] w_ret_mask;
    logic                  w_arb_valid;
    logic                  w_grant;
    logic [SW-1:0]         w_arb_idx;
    logic [SW-1:0]         w_ptr_next;
    tag_t                  w_tail;

    // A stage with a read in flight is masked even if it keeps req high
    assign w_eligible = req & ~r_outstanding;

    rr_arbiter #(
        .NUM_STAGES (NUM_STAGES)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_valid    (w_arb_valid),
        .o_idx      (w_arb_idx)
    );

    // A pending configuration request blocks new grants in the same cycle
    assign w_grant      = (r_state == RUN) && !cfgValid && w_arb_valid;
    assign w_grant_mask = w_grant ? (NUM_STAGES'(1) << w_arb_idx) : '0;
    assign w_ptr_next   = (w_arb_idx == SW'(NUM_STAGES - 1)) ? '0 : w_arb_idx + 1'b1;
    assign w_tail       = r_tags[RD_LAT-1];

    // Decode the tag leaving the pipe into a one-hot return vector
    always_comb begin
        w_ret_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_ret_mask[i] = w_tail.valid && (w_tail.stage == c_STAGE_IDX_W'(i));
        end
    end

    // RAM strobes follow the arbitration result or the accepted config write in the same cycle
    always_comb begin
        ramEn    = 1'b0;
        ramWe    = 1'b0;
        ramAddr  = '0;
        ramWdata = '0;
        if (w_grant) begin
            ramEn   = 1'b1;
            ramAddr = reqAddr[w_arb_idx*AW +: AW];
        end else if ((r_state == CFG) && cfgValid) begin
            ramEn    = 1'b1;
            ramWe    = 1'b1;
            ramAddr  = cfgAddr;
            ramWdata = cfgData;
        end
    end

    assign cfgReady = (r_state == CFG);
    assign busy     = (r_inflight != '0) || (r_state != RUN);

    // Control FSM, round-robin pointer, outstanding mask, in-flight count and read return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_ptr         <= '0;
            r_outstanding <= '0;
            r_inflight    <= '0;
            memRdy        <= '0;
            rdData        <= '0;
        end else begin
            case (r_state)
                RUN:     if (cfgValid)             r_state <= DRAIN;
                DRAIN:   if (r_inflight == '0)     r_state <= CFG;
                CFG:     if (!cfgValid)            r_state <= RUN;
                default:                           r_state <= RUN;
            endcase
            if (w_grant) begin
                r_ptr <= w_ptr_next;
            end
            r_outstanding <= (r_outstanding & ~w_ret_mask) | w_grant_mask;
            memRdy        <= w_ret_mask;
            if (w_tail.valid) begin
                rdData <= ramRdata;
            end
            case ({w_grant, w_tail.valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Tag pipe tracks which stage owns the RAM data emerging RD_LAT cycles later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            r_tags[0] <= '{valid: w_grant, stage: c_STAGE_IDX_W'(w_arb_idx)};
            for (int i = 1; i < RD_LAT; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

`ifdef TREE_MEM_STATS_EN
    logic w_stall;
    assign w_stall = (|req) && !w_grant;

    // Saturating grant and stall statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grantCount <= '0;
            stallCount <= '0;
        end else begin
            if (w_grant && (grantCount != '1)) begin
                grantCount <= grantCount + 1'b1;
            end
            if (w_stall && (stallCount != '1)) begin
                stallCount <= stallCount + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/tree_node_mem_arbiter.md
# tree_node_mem_arbiter

Shares one single-ported, synchronous node-parameter RAM between the NUM_STAGES branch/leaf stages of the decision-tree pipeline. The block round-robin arbitrates stage read requests, returns each stage's node word together with that stage's memRdy pulse, and provides a configuration write port for loading node parameters. Before any configuration write is performed, all outstanding reads are drained.

## Interface
- NUM_STAGES, 4: number of requesting pipeline stages (≥2)
- NUM_NODES, 32: RAM depth; AW = $clog2(NUM_NODES)
- WORD_W, 64: node word width (2*DATA_SIZE, or 3*DATA_SIZE for leaves)
- RD_LAT, 1: RAM read latency in cycles (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_STAGES  stage s requests a read; held until its memRdy
- reqAddr  in  NUM_STAGES*AW  stage s address at [s*AW +: AW]
- memRdy  out  NUM_STAGES  one-cycle pulse: rdData valid for stage s
- rdData  out  WORD_W  shared registered read-data bus
- cfgValid  in  1  configuration write request
- cfgAddr  in  AW  write address
- cfgData  in  WORD_W  write data
- cfgReady  out  1  write accepted when cfgValid & cfgReady
- ramEn  out  1  RAM access strobe
- ramWe  out  1  RAM write enable
- ramAddr  out  AW  RAM address
- ramWdata  out  WORD_W  RAM write data
- ramRdata  in  WORD_W  RAM read data, valid RD_LAT cycles after ramEn & ~ramWe
- busy  out  1  reads in flight or state ≠ RUN

## Operation
- FSM states: RUN (reset state), DRAIN, CFG.
- RUN:
  - Eligible = req & ~outstanding.
  - If cfgValid=1: go to DRAIN and issue no grant this cycle.
  - Otherwise, grant the first eligible stage searching from ptr upward with wrap-around.
  - Grant g drives ramEn=1, ramWe=0, ramAddr=reqAddr[g]; sets outstanding[g]; sets ptr=(g+1) mod NUM_STAGES.
- DRAIN: no grants. When the in-flight count is 0, go to CFG.
- CFG:
  - cfgReady=1.
  - When cfgValid=1: ramEn=1, ramWe=1, ramAddr=cfgAddr, ramWdata=cfgData; one write per cycle.
  - When cfgValid=0: return to RUN.
- Read return:
  - A tag shift register of depth RD_LAT carries {valid, stage index}.
  - At the tail, rdData←ramRdata, memRdy[tag]←1, and outstanding[tag] is cleared.
- In-flight counter, width $clog2(RD_LAT+1)+1: increments on grant, decrements on return; both in the same cycle means no change.
- A stage whose outstanding bit is set is masked from arbitration, even if req stays high.
- At most one grant per cycle, so at most one memRdy bit is high per cycle.

## Timing
- Reset values:
  - memRdy, cfgReady, ramEn, ramWe: 0.
  - rdData, ramAddr, ramWdata: 0.
  - busy: 0; ptr: 0; outstanding: 0; tags invalid; state: RUN.
- ramEn, ramAddr and ramWe are combinational from the arbitration result in the grant cycle t.
- memRdy[g] and rdData are registered and appear in cycle t+RD_LAT+1. With RD_LAT=1 this is t+2.
- Throughput: one read per cycle across stages. A single stage gets at most one read per RD_LAT+1 cycles.
- Reset mid-operation: in-flight reads are discarded, no memRdy is produced, and the FSM returns to RUN.
- cfgValid rising while reads are in flight: those reads still return normally during DRAIN.
- A request with no eligible stage leaves ptr unchanged.

## Configuration
- TREE_MEM_STATS_EN defined:
  - Adds outputs grantCount (32) and stallCount (32); both reset to 0 and saturate at all-ones.
  - grantCount increments on each read grant.
  - stallCount increments in each cycle where any req bit is high but no grant is issued.
- TREE_MEM_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- tree_mem_pkg contains:
  - the state enum {RUN, DRAIN, CFG};
  - the tag struct {logic valid; stage index};
  - an addr-width localparam helper.
- Sub-module rr_arbiter (NUM_STAGES): inputs are the eligible vector and ptr; outputs are grant valid and grant index. It is purely combinational; the ptr register lives in the parent.

## Test plan
- Single request: req[0]=1, reqAddr0=5 at t, RAM[5]=0xA5 → ramAddr=5 at t; memRdy[0]=1 and rdData=0xA5 at t+2 (RD_LAT=1).
- Round robin: req=4'b1111 held, requests re-raised after each memRdy → grant order 0,1,2,3,0; no stage granted twice while outstanding.
- Config drain: grant stage 2 at t, cfgValid=1 at t+1 → memRdy[2] at t+2; cfgReady=1 at t+3; write RAM[7]=0x3C.
- Write/read-back: after the write above, cfgValid=0, then req[1]=1 addr 7 → rdData=0x3C with memRdy[1].
- Reset mid-flight: grant at t, rst pulse at t+1 → memRdy stays 0; busy=0; the next grant starts search at stage 0.
- Stats (macro on): 3 grants plus 2 stalled cycles → grantCount=3, stallCount=2.
